// File: rtl/musica_pkg.sv
// Shared definitions for the song sequencer: FSM encoding, timing default,
// memory address limits and the tempo counter width helper.
package musica_pkg;

    typedef enum logic [2:0] {
        OCIOSO,
        CARREGA,
        AVALIA,
        TOCA,
        PROXIMO,
        GRAVA,
        ESCREVE_FIM,
        FIM
    } estado_t;

    localparam int unsigned TICKS_POR_TEMPO_PADRAO = 12500000;

    // Last address of a song slot, and the last one a recorded entry may use
    // (the slot after it is reserved for the terminator).
    localparam logic [4:0] ULTIMO_ENDERECO = 5'd31;
    localparam logic [4:0] ULTIMO_DADO     = 5'd30;

    // Bits needed to hold 15 tempo units worth of clock ticks.
    function automatic int unsigned largura_contador(input int unsigned ticks);
        return (ticks == 0) ? 1 : int'($clog2(15 * ticks + 1));
    endfunction

endpackage

// File: rtl/contador_tempo.sv
// Loadable down-counter that times how long a note is held; stops at zero.
module contador_tempo #(
    parameter int unsigned LARGURA = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               carregar_i,
    input  logic [LARGURA-1:0] valor_i,
    input  logic               habilitar_i,
    output logic               zero_o
);

    logic [LARGURA-1:0] contagem_q, contagem_d;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        contagem_d = contagem_q;
        if (carregar_i) begin
            contagem_d = valor_i;
        end else if (habilitar_i && (contagem_q != '0)) begin
            contagem_d = contagem_q - LARGURA'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contagem_q <= '0;
        end else begin
            contagem_q <= contagem_d;
        end
    end

    assign zero_o = (contagem_q == '0);

endmodule

// File: rtl/sequenciador_musica.sv
// Song sequencer: plays (nota, tempo) entries from an external song memory
// and records strobed entries into it, terminating each song with a 0/0 entry.
module sequenciador_musica
    import musica_pkg::*;
#(
    parameter int unsigned TICKS_POR_TEMPO = TICKS_POR_TEMPO_PADRAO
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iniciar,
    input  logic       gravar,
    input  logic       parar,
    input  logic [3:0] musica_sel,
    input  logic [3:0] nota_in,
    input  logic [3:0] tempo_in,
    input  logic       nota_valida,
    input  logic [3:0] mem_nota,
    input  logic [3:0] mem_tempo,
    input  logic       mem_fim,
    output logic       mem_we,
    output logic [4:0] mem_addr,
    output logic [3:0] mem_musica,
    output logic [3:0] mem_data_nota,
    output logic [3:0] mem_data_tempo,
    output logic [3:0] nota_atual,
    output logic       tocando,
    output logic       gravando,
    output logic       pronto
);

    localparam int unsigned LARGURA_CONT = largura_contador(TICKS_POR_TEMPO);

    estado_t                 estado_q, estado_d;
    logic [4:0]              addr_q, addr_d;
    logic [3:0]              musica_q, musica_d;
    logic [3:0]              nota_q, nota_d;
    logic                    carregar, habilitar, contador_zero;
    logic                    entrada_valida;
    logic [LARGURA_CONT-1:0] carga_tempo;

    // TOCA leaves on the cycle the counter reads zero, so loading N-1 gives exactly N cycles.
    assign carga_tempo    = LARGURA_CONT'(32'(mem_tempo) * TICKS_POR_TEMPO - 32'd1);
    assign entrada_valida = nota_valida && ({nota_in, tempo_in} != 8'd0);

    contador_tempo #(
        .LARGURA (LARGURA_CONT)
    ) u_contador_tempo (
        .clk         (clk),
        .rst_n       (rst_n),
        .carregar_i  (carregar),
        .valor_i     (carga_tempo),
        .habilitar_i (habilitar),
        .zero_o      (contador_zero)
    );

    always_comb begin
        estado_d       = estado_q;
        addr_d         = addr_q;
        musica_d       = musica_q;
        nota_d         = nota_q;
        carregar       = 1'b0;
        habilitar      = 1'b0;
        mem_we         = 1'b0;
        mem_data_nota  = 4'd0;
        mem_data_tempo = 4'd0;

        unique case (estado_q)
            OCIOSO: begin
                if (!parar && (gravar || iniciar)) begin
                    musica_d = musica_sel;
                    addr_d   = 5'd0;
                    estado_d = gravar ? GRAVA : CARREGA;
                end
            end
            CARREGA: estado_d = parar ? OCIOSO : AVALIA;
            AVALIA: begin
                if (parar) begin
                    estado_d = OCIOSO;
                end else if (mem_fim) begin
                    estado_d = FIM;
                end else begin
                    nota_d = mem_nota;
                    if (mem_tempo == 4'd0) begin
                        estado_d = PROXIMO;
                    end else begin
                        carregar = 1'b1;
                        estado_d = TOCA;
                    end
                end
            end
            TOCA: begin
                if (parar) begin
                    estado_d = OCIOSO;
                end else if (contador_zero) begin
                    estado_d = PROXIMO;
                end else begin
                    habilitar = 1'b1;
                end
            end
            PROXIMO: begin
                if (parar) begin
                    estado_d = OCIOSO;
                end else if (addr_q == ULTIMO_ENDERECO) begin
                    estado_d = FIM;
                end else begin
                    addr_d   = addr_q + 5'd1;
                    estado_d = CARREGA;
                end
            end
            GRAVA: begin
                if (parar) begin
                    estado_d = ESCREVE_FIM;
                end else if (entrada_valida) begin
                    mem_we         = 1'b1;
                    mem_data_nota  = nota_in;
                    mem_data_tempo = tempo_in;
                    addr_d         = addr_q + 5'd1;
                    if (addr_q == ULTIMO_DADO) begin
                        estado_d = ESCREVE_FIM;
                    end
                end
            end
            ESCREVE_FIM: begin
                mem_we   = 1'b1;
                estado_d = FIM;
            end
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase

        // Song selection and address are released whenever the sequencer goes idle.
        if (estado_d == OCIOSO) begin
            addr_d   = 5'd0;
            musica_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            addr_q   <= 5'd0;
            musica_q <= 4'd0;
            nota_q   <= 4'd0;
        end else begin
            estado_q <= estado_d;
            addr_q   <= addr_d;
            musica_q <= musica_d;
            nota_q   <= nota_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_musica = musica_q;
    assign nota_atual = (estado_q == TOCA) ? nota_q : 4'd0;
    assign tocando    = (estado_q inside {CARREGA, AVALIA, TOCA, PROXIMO});
    assign gravando   = (estado_q inside {GRAVA, ESCREVE_FIM});
    assign pronto     = (estado_q == FIM);

endmodule

// File: doc/sequenciador_musica.md
SEQUENCIADOR_MUSICA -- requirements
Module: sequenciador_musica

Interface
REQ-001 SHALL have parameter TICKS_POR_TEMPO, default 12500000, clk cycles per tempo unit (0.25 s at 50 MHz).
REQ-002 SHALL have port clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port iniciar  in  1  start playback of musica_sel (level sampled per cycle).
REQ-005 SHALL have port gravar  in  1  start recording into musica_sel.
REQ-006 SHALL have port parar  in  1  abort playback / terminate recording.
REQ-007 SHALL have port musica_sel  in  4  song index.
REQ-008 SHALL have ports nota_in, tempo_in  in  4 each, and nota_valida  in  1  (one-cycle strobe of an entry to record).
REQ-009 SHALL have ports mem_nota, mem_tempo  in  4 each, and mem_fim  in  1  (song memory read data and terminator flag).
REQ-010 SHALL have ports mem_we  out  1, mem_addr  out  5, mem_musica  out  4, mem_data_nota  out  4, mem_data_tempo  out  4  (song memory control).
REQ-011 SHALL have ports nota_atual  out  4, tocando  out  1, gravando  out  1, pronto  out  1  (one-cycle done pulse).

Function
REQ-012 SHALL implement states OCIOSO, CARREGA, AVALIA, TOCA, PROXIMO, GRAVA, ESCREVE_FIM, FIM.
REQ-013 In OCIOSO, command priority SHALL be parar > gravar > iniciar; commands outside OCIOSO other than parar SHALL be ignored.
REQ-014 On accepted command, musica_sel SHALL be latched into mem_musica and held until return to OCIOSO; mem_addr SHALL be set to 0.
REQ-015 Memory read latency SHALL be one cycle: CARREGA presents mem_addr, AVALIA samples mem_nota/mem_tempo/mem_fim.
REQ-016 AVALIA: mem_fim=1 -> FIM; else nota_atual<=mem_nota, counter loaded with mem_tempo*TICKS_POR_TEMPO; if mem_tempo=0 -> PROXIMO directly.
REQ-017 TOCA SHALL last exactly mem_tempo*TICKS_POR_TEMPO cycles, then PROXIMO.
REQ-018 PROXIMO: mem_addr=31 -> FIM (no wrap-around); else mem_addr+1 and CARREGA.
REQ-019 Counter width SHALL hold 15*TICKS_POR_TEMPO without overflow.
REQ-020 GRAVA: on nota_valida with {nota_in,tempo_in}≠0, mem_we=1 for one cycle with data at mem_addr, then mem_addr+1; entries of 0/0 SHALL be ignored.
REQ-021 After writing address 30, or on parar in GRAVA, SHALL go to ESCREVE_FIM: one-cycle write of nota=0,tempo=0 at current mem_addr, then FIM.
REQ-022 nota_valida coincident with parar SHALL be discarded; parar wins.
REQ-023 parar during CARREGA/AVALIA/TOCA/PROXIMO SHALL go to OCIOSO next cycle without pronto.
REQ-024 FIM SHALL assert pronto for one cycle and return to OCIOSO.
REQ-025 tocando=1 in CARREGA..PROXIMO; gravando=1 in GRAVA/ESCREVE_FIM; nota_atual=0 whenever not in TOCA.
REQ-026 mem_we SHALL never be asserted outside GRAVA/ESCREVE_FIM.

Reset
REQ-027 rst_n low SHALL immediately force OCIOSO, counter 0, mem_addr 0, mem_musica 0, mem_we 0, data 0, nota_atual 0, tocando 0, gravando 0, pronto 0, including mid-write.

Structure
REQ-028 State encodings, TICKS_POR_TEMPO default and 5-bit last-address constant (31) SHALL live in shared package musica_pkg.
REQ-029 Tempo down-counter SHALL be sub-module contador_tempo (load, enable, zero flag).

Verification (TICKS_POR_TEMPO=4)
REQ-030 Song 3 = {(5,2),(7,1),(0,0)}, iniciar -> nota_atual 5 for 8 cycles, 7 for 4 cycles, pronto pulse, mem_we never 1.
REQ-031 gravar song 2, strobes (9,3),(4,2), then parar -> writes at addr 0,1 then (0,0) at addr 2, pronto; replay gives 9 for 12, 4 for 8 cycles.
REQ-032 Record 31 valid strobes -> auto terminator at addr 31, pronto, 32nd strobe ignored.
REQ-033 Playback of full 32 entries without terminator -> stops after addr 31, mem_addr never wraps to 0.
REQ-034 parar in TOCA, and rst_n low during ESCREVE_FIM -> OCIOSO next cycle/immediately, all outputs 0, no pronto.
REQ-035 iniciar and gravar same cycle -> recording starts; iniciar during playback ignored; entry (6,0) skipped in 0 TOCA cycles.
